// File: rtl/ret_addr_stack_pkg.sv
// Shared CPU definitions used by the return-address stack: PC width,
// return-mode encoding and the per-edge operation decode.
package ret_addr_stack_pkg;

  localparam int PC_W      = 10;
  localparam int RAS_DEPTH = 16;

  // Return-mode encoding carried on the interrupt input.
  localparam logic RET_CALL = 1'b0;
  localparam logic RET_INT  = 1'b1;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_POP,
    OP_PUSH,
    OP_REPLACE,
    OP_FLUSH
  } ras_op_e;

  // flush beats a paired push+pop, which beats a lone push, which beats a lone pop.
  function automatic ras_op_e decode_op(input logic push, input logic pop, input logic flush);
    ras_op_e op;
    op = OP_IDLE;
    if (flush)             op = OP_FLUSH;
    else if (push && pop)  op = OP_REPLACE;
    else if (push)         op = OP_PUSH;
    else if (pop)          op = OP_POP;
    return op;
  endfunction

endpackage

// File: rtl/ret_addr_stack_if.sv
// Control-unit <-> return-address-stack bundle: command strobes, push data,
// resume address and stack status.
interface ret_addr_stack_if
  import ret_addr_stack_pkg::*;
#(
  parameter int ADDR_W = PC_W,
  parameter int DEPTH  = RAS_DEPTH
);
  localparam int PTR_W = $clog2(DEPTH);

  logic              push;
  logic              pop;
  logic              interrupt;
  logic              flush;
  logic              err_clr;
  logic [ADDR_W-1:0] pc_addr;
  logic [ADDR_W-1:0] out;
  logic [PTR_W:0]    count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, pop, interrupt, flush, err_clr, pc_addr,
    input  out, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, interrupt, flush, err_clr, pc_addr,
    output out, count, empty, full, overflow, underflow
  );

endinterface

// File: rtl/ret_addr_stack_stack_ram.sv
// DEPTH x ADDR_W register file: one synchronous write port, one asynchronous
// read port, no reset.
module stack_ram #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [ADDR_W-1:0] rdata
);

  logic [ADDR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ret_addr_stack.sv
// Hardware return-address stack: occupancy counter, sticky error flags and
// the call/interrupt resume-address adder around a small register file.
module ret_addr_stack
  import ret_addr_stack_pkg::*;
#(
  parameter int ADDR_W = PC_W,
  parameter int DEPTH  = RAS_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  ret_addr_stack_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]    FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0]  IDX_ONE  = PTR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [PTR_W:0]    cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              is_empty, is_full;
  logic              we_raw, we;
  logic [PTR_W-1:0]  waddr, top_idx;
  logic [ADDR_W-1:0] top_data, ret_addr;
  ras_op_e           op;

  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == FULL_CNT);
  // Low bits wrap to DEPTH-1 when the stack is full, which is exactly the top slot.
  assign top_idx  = cnt_q[PTR_W-1:0] - IDX_ONE;
  assign op       = decode_op(bus.push, bus.pop, bus.flush);

  always_comb begin
    cnt_d  = cnt_q;
    ovf_d  = ovf_q & ~bus.err_clr;
    unf_d  = unf_q & ~bus.err_clr;
    we_raw = 1'b0;
    waddr  = cnt_q[PTR_W-1:0];
    unique case (op)
      OP_FLUSH: cnt_d = '0;
      OP_REPLACE: begin
        if (!is_empty) begin
          we_raw = 1'b1;
          waddr  = top_idx;
        end else begin
          unf_d = 1'b1;
        end
      end
      OP_PUSH: begin
        if (!is_full) begin
          we_raw = 1'b1;
          cnt_d  = cnt_q + CNT_ONE;
        end else begin
          ovf_d = 1'b1;
        end
      end
      OP_POP: begin
        if (!is_empty) cnt_d = cnt_q - CNT_ONE;
        else           unf_d = 1'b1;
      end
      default: ;
    endcase
  end

  // A write landing while reset is held would be aborted anyway; keep the RAM quiet.
  assign we = we_raw & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  stack_ram #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (bus.pc_addr),
    .raddr (top_idx),
    .rdata (top_data)
  );

  // Call returns resume after the call instruction; interrupt returns re-run the saved PC.
  always_comb begin
    ret_addr = top_data;
    if (bus.interrupt == RET_CALL) ret_addr = top_data + ADDR_ONE;
    if (is_empty) ret_addr = '0;
  end

  assign bus.out       = ret_addr;
  assign bus.count     = cnt_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule

// File: tb/tb_ret_addr_stack.sv
// Bench for ret_addr_stack: a 10-bit/16-deep and a 16-bit/4-deep instance share
// one stimulus stream and are checked against queue-based stack models.
module tb_ret_addr_stack;
  import ret_addr_stack_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        push, pop, intr, flush, err_clr;
  logic [15:0] pc;
  logic        chk_en;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  ret_addr_stack_if #(.ADDR_W(10), .DEPTH(16)) bus_a ();
  ret_addr_stack_if #(.ADDR_W(16), .DEPTH(4))  bus_b ();

  assign bus_a.push = push;       assign bus_b.push = push;
  assign bus_a.pop = pop;         assign bus_b.pop = pop;
  assign bus_a.interrupt = intr;  assign bus_b.interrupt = intr;
  assign bus_a.flush = flush;     assign bus_b.flush = flush;
  assign bus_a.err_clr = err_clr; assign bus_b.err_clr = err_clr;
  assign bus_a.pc_addr = pc[9:0]; assign bus_b.pc_addr = pc;

  ret_addr_stack #(.ADDR_W(10), .DEPTH(16)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  ret_addr_stack #(.ADDR_W(16), .DEPTH(4))  dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stack models: queue back is the top of stack.
  logic [9:0]  qa[$];
  logic [15:0] qb[$];
  logic        ova, una, ovb, unb;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      qa.delete();
      qb.delete();
      ova <= 1'b0; una <= 1'b0; ovb <= 1'b0; unb <= 1'b0;
    end else begin
      ova <= (!flush && push && !pop && qa.size() == 16) | (ova & !err_clr);
      ovb <= (!flush && push && !pop && qb.size() == 4)  | (ovb & !err_clr);
      una <= (!flush && pop && qa.size() == 0) | (una & !err_clr);
      unb <= (!flush && pop && qb.size() == 0) | (unb & !err_clr);
      if (flush) begin
        qa.delete();
        qb.delete();
      end else if (push && pop) begin
        if (qa.size() > 0) begin void'(qa.pop_back()); qa.push_back(pc[9:0]); end
        if (qb.size() > 0) begin void'(qb.pop_back()); qb.push_back(pc); end
      end else if (push) begin
        if (qa.size() < 16) qa.push_back(pc[9:0]);
        if (qb.size() < 4)  qb.push_back(pc);
      end else if (pop) begin
        if (qa.size() > 0) void'(qa.pop_back());
        if (qb.size() > 0) void'(qb.pop_back());
      end
    end
  end

  function automatic logic [31:0] exp_out_a();
    logic [9:0] t;
    if (qa.size() == 0) return 32'd0;
    t = qa[qa.size()-1];
    if (!intr) t = t + 10'd1;
    return {22'd0, t};
  endfunction

  function automatic logic [31:0] exp_out_b();
    logic [15:0] t;
    if (qb.size() == 0) return 32'd0;
    t = qb[qb.size()-1];
    if (!intr) t = t + 16'd1;
    return {16'd0, t};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_count", 32'(bus_a.count), 32'(qa.size()));
      chk("a_empty", 32'(bus_a.empty), 32'(qa.size() == 0));
      chk("a_full",  32'(bus_a.full),  32'(qa.size() == 16));
      chk("a_out",   32'(bus_a.out),   exp_out_a());
      chk("a_ovf",   32'(bus_a.overflow),  32'(ova));
      chk("a_unf",   32'(bus_a.underflow), 32'(una));
      chk("b_count", 32'(bus_b.count), 32'(qb.size()));
      chk("b_empty", 32'(bus_b.empty), 32'(qb.size() == 0));
      chk("b_full",  32'(bus_b.full),  32'(qb.size() == 4));
      chk("b_out",   32'(bus_b.out),   exp_out_b());
      chk("b_ovf",   32'(bus_b.overflow),  32'(ovb));
      chk("b_unf",   32'(bus_b.underflow), 32'(unb));
    end
  end

  task automatic tick(input logic p, input logic o, input logic f, input logic e, input logic [15:0] a);
    push = p; pop = o; flush = f; err_clr = e; pc = a;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0;
  endtask

  task automatic set_intr(input logic v);
    intr = v;
    #1;
  endtask

  initial begin
    chk_en = 1'b0;
    reset = 1'b0;
    push = 1'b0; pop = 1'b0; intr = RET_CALL; flush = 1'b0; err_clr = 1'b0; pc = '0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1 chk_en = 1'b1;

    chk("rst_count", 32'(bus_a.count), 32'd0);
    chk("rst_empty", 32'(bus_a.empty), 32'd1);
    chk("rst_full",  32'(bus_a.full),  32'd0);
    chk("rst_out",   32'(bus_a.out),   32'd0);
    chk("rst_ovf",   32'(bus_a.overflow),  32'd0);
    chk("rst_unf",   32'(bus_a.underflow), 32'd0);

    tick(1, 0, 0, 0, 16'h010);
    tick(1, 0, 0, 0, 16'h020);
    chk("two_count", 32'(bus_a.count), 32'd2);
    set_intr(RET_CALL);
    chk("two_call", 32'(bus_a.out), 32'h021);
    set_intr(RET_INT);
    chk("two_int", 32'(bus_a.out), 32'h020);
    chk("two_int_b", 32'(bus_b.out), 32'h020);
    set_intr(RET_CALL);
    tick(0, 1, 0, 0, 16'h0);
    chk("pop_out", 32'(bus_a.out), 32'h011);
    chk("pop_count", 32'(bus_a.count), 32'd1);
    tick(0, 1, 0, 0, 16'h0);

    for (int i = 0; i < 16; i++) tick(1, 0, 0, 0, 16'h100 + 16'(i));
    tick(1, 0, 0, 0, 16'h3FF);
    set_intr(RET_INT);
    chk("fill_full",  32'(bus_a.full), 32'd1);
    chk("fill_ovf",   32'(bus_a.overflow), 32'd1);
    chk("fill_count", 32'(bus_a.count), 32'd16);
    chk("fill_top",   32'(bus_a.out), 32'h10F);
    chk("fill_b_count", 32'(bus_b.count), 32'd4);
    chk("fill_b_top",   32'(bus_b.out), 32'h103);
    chk("fill_b_ovf",   32'(bus_b.overflow), 32'd1);
    tick(1, 1, 0, 0, 16'h155);
    chk("full_repl_top", 32'(bus_a.out), 32'h155);
    chk("full_repl_ovf_kept", 32'(bus_a.overflow), 32'd1);
    tick(0, 0, 0, 1, 16'h0);
    chk("errclr_ovf", 32'(bus_a.overflow), 32'd0);
    chk("errclr_b_ovf", 32'(bus_b.overflow), 32'd0);
    set_intr(RET_CALL);

    tick(0, 0, 1, 0, 16'h0);
    tick(1, 0, 0, 0, 16'h001);
    tick(1, 0, 0, 0, 16'h002);
    tick(1, 0, 0, 0, 16'h003);
    tick(1, 1, 0, 0, 16'h2AA);
    chk("repl_count", 32'(bus_a.count), 32'd3);
    chk("repl_out",   32'(bus_a.out), 32'h2AB);
    repeat (3) tick(0, 1, 0, 0, 16'h0);
    chk("drain_empty", 32'(bus_a.empty), 32'd1);

    tick(0, 1, 0, 0, 16'h0);
    chk("unf_set",   32'(bus_a.underflow), 32'd1);
    chk("unf_count", 32'(bus_a.count), 32'd0);
    tick(0, 1, 0, 1, 16'h0);
    chk("unf_set_wins", 32'(bus_a.underflow), 32'd1);
    tick(1, 1, 0, 1, 16'h0AA);
    chk("repl_empty_unf", 32'(bus_a.underflow), 32'd1);
    chk("repl_empty_cnt", 32'(bus_a.count), 32'd0);
    tick(0, 0, 0, 1, 16'h0);
    chk("unf_clr", 32'(bus_a.underflow), 32'd0);

    tick(1, 0, 0, 0, 16'hFFFF);
    chk("wrap_a", 32'(bus_a.out), 32'h000);
    chk("wrap_b", 32'(bus_b.out), 32'h0000);
    set_intr(RET_INT);
    chk("nowrap_a", 32'(bus_a.out), 32'h3FF);
    chk("nowrap_b", 32'(bus_b.out), 32'hFFFF);
    set_intr(RET_CALL);

    for (int i = 0; i < 4; i++) tick(1, 0, 0, 0, 16'h200 + 16'(i));
    chk("pre_flush_count", 32'(bus_a.count), 32'd5);
    tick(0, 0, 1, 0, 16'h0);
    chk("flush_count", 32'(bus_a.count), 32'd0);
    chk("flush_empty", 32'(bus_a.empty), 32'd1);
    chk("flush_keeps_ovf_b", 32'(bus_b.overflow), 32'd1);
    tick(1, 1, 1, 0, 16'h123);
    chk("flush_prio", 32'(bus_a.count), 32'd0);

    tick(1, 0, 0, 0, 16'h0AB);
    tick(1, 0, 0, 0, 16'h0CD);
    push = 1'b1; pc = 16'h0EF;
    #2 reset = 1'b0;
    #1;
    chk("async_rst_a", 32'(bus_a.count), 32'd0);
    chk("async_rst_b", 32'(bus_b.count), 32'd0);
    chk("async_rst_ovf_b", 32'(bus_b.overflow), 32'd0);
    push = 1'b0;
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    tick(1, 0, 0, 0, 16'h045);
    chk("post_rst_out", 32'(bus_a.out), 32'h046);
    chk("post_rst_count", 32'(bus_a.count), 32'd1);

    repeat (3) tick(0, 0, 0, 0, 16'h0);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
